// File: rtl/rr_arb2_mux_feed.sv
// rr_arb2_mux_feed: two-channel round-robin arbiter with a per-grant burst
// limit. It drives the select of the downstream 2:1 mux with the current
// grant and presents the granted word through a single-entry registered
// output stage with a valid/ready handshake.
module rr_arb2_mux_feed #(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    // Arbiter states. Grant states encode the granted channel directly.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // Burst limit as a 4-bit value. The legal MAX_BURST range is 1..15.
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // Map a channel index onto its grant state.
    function automatic logic [1:0] grant_state(input logic ch);
        if (ch) begin
            return ST_GRANT1;
        end else begin
            return ST_GRANT0;
        end
    endfunction

    // Registered state
    logic [1:0]        state_r;
    logic              sel_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [3:0]        burst_cnt_r;
    logic              last_served_r;

    // Combinational decode
    logic              granted_s;
    logic              gch_s;
    logic              can_load_s;
    logic              g_valid_s;
    logic              o_valid_s;
    logic              xfer_s;
    logic [DATA_W-1:0] g_data_s;
    logic [3:0]        cnt_next_s;

    // Next-state values
    logic [1:0]        state_next_s;
    logic              sel_next_s;
    logic [3:0]        burst_cnt_next_s;
    logic              last_served_next_s;

    // Decode the current grant, the output-slot availability and the transfer.
    always_comb begin
        granted_s  = (state_r == ST_GRANT0) || (state_r == ST_GRANT1);
        gch_s      = (state_r == ST_GRANT1);
        // The slot can take a word if it is empty or is being drained now.
        can_load_s = !out_valid_r || out_ready;
        if (gch_s) begin
            g_valid_s = in1_valid;
            o_valid_s = in0_valid;
            g_data_s  = in1_data;
        end else begin
            g_valid_s = in0_valid;
            o_valid_s = in1_valid;
            g_data_s  = in0_data;
        end
        xfer_s     = granted_s && g_valid_s && can_load_s;
        // Only completed transfers advance the burst, so stalls never count.
        cnt_next_s = burst_cnt_r + {3'b000, xfer_s};
    end

    assign in0_ready = (state_r == ST_GRANT0) && can_load_s;
    assign in1_ready = (state_r == ST_GRANT1) && can_load_s;

    // Arbitration: pick the next grant, burst count and last-served channel.
    always_comb begin
        state_next_s       = state_r;
        burst_cnt_next_s   = burst_cnt_r;
        last_served_next_s = last_served_r;
        case (state_r)
            ST_IDLE: begin
                burst_cnt_next_s = 4'd0;
                if (in0_valid && in1_valid) begin
                    // Contention: the channel not served most recently wins.
                    state_next_s = grant_state(!last_served_r);
                end else if (in0_valid) begin
                    state_next_s = ST_GRANT0;
                end else if (in1_valid) begin
                    state_next_s = ST_GRANT1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (cnt_next_s == BURST_LIMIT) begin
                    // Burst exhausted: hand over only if the other side wants it.
                    burst_cnt_next_s = 4'd0;
                    if (o_valid_s) begin
                        state_next_s       = grant_state(!gch_s);
                        last_served_next_s = gch_s;
                    end else begin
                        state_next_s       = state_r;
                        last_served_next_s = last_served_r;
                    end
                end else if (!g_valid_s) begin
                    // Granted producer went quiet: release the grant.
                    burst_cnt_next_s   = 4'd0;
                    last_served_next_s = gch_s;
                    if (o_valid_s) begin
                        state_next_s = grant_state(!gch_s);
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s     = state_r;
                    burst_cnt_next_s = cnt_next_s;
                end
            end
            default: begin
                state_next_s       = ST_IDLE;
                burst_cnt_next_s   = 4'd0;
                last_served_next_s = last_served_r;
            end
        endcase
    end

    // Mux select follows the next grant and holds its value through IDLE.
    always_comb begin
        case (state_next_s)
            ST_GRANT0: sel_next_s = 1'b0;
            ST_GRANT1: sel_next_s = 1'b1;
            default:   sel_next_s = sel_r;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            sel_r         <= 1'b0;
            burst_cnt_r   <= 4'd0;
            last_served_r <= 1'b1;
        end else begin
            state_r       <= state_next_s;
            sel_r         <= sel_next_s;
            burst_cnt_r   <= burst_cnt_next_s;
            last_served_r <= last_served_next_s;
        end
    end

    // Single-entry output stage: a new load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= g_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign sel       = sel_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_rr_arb2_mux_feed.sv
// Directed self-checking bench for rr_arb2_mux_feed (DATA_W=8, MAX_BURST=4).
module tb_rr_arb2_mux_feed;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_ready;
    logic          sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    int total;
    int bad;

    rr_arb2_mux_feed #(.DATA_W(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = 8'h00;
        in1_data  = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h5A;
        in1_data  = 8'hA5;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b exp=0", sel); end
        total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL reset_in0_ready got=%b exp=0", in0_ready); end
        total++; if (in1_ready !== 1'b0) begin bad++; $display("FAIL reset_in1_ready got=%b exp=0", in1_ready); end
    endtask

    task automatic test_ch0_only();
        logic [DW-1:0] exp_d;
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 8'h00;
        out_ready = 1'b1;
        tick();
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL ch0_grant_sel got=%b exp=0", sel); end
        total++; if (in0_ready !== 1'b1) begin bad++; $display("FAIL ch0_grant_ready got=%b exp=1", in0_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ch0_grant_out_valid got=%b exp=0", out_valid); end
        for (int k = 0; k < 12; k++) begin
            exp_d    = k[0] ? 8'h01 : 8'h00;
            in0_data = exp_d;
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ch0_out_valid k=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_data !== exp_d) begin bad++; $display("FAIL ch0_out_data k=%0d got=%h exp=%h", k, out_data, exp_d); end
            total++; if (sel !== 1'b0) begin bad++; $display("FAIL ch0_sel k=%0d got=%b exp=0", k, sel); end
            total++; if (in0_ready !== 1'b1) begin bad++; $display("FAIL ch0_in0_ready k=%0d got=%b exp=1", k, in0_ready); end
            total++; if (in1_ready !== 1'b0) begin bad++; $display("FAIL ch0_in1_ready k=%0d got=%b exp=0", k, in1_ready); end
        end
    endtask

    task automatic test_round_robin();
        logic          exp_sel;
        logic [DW-1:0] exp_d;
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB1;
        out_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            exp_sel = 1'(((n - 1) / 4) % 2);
            total++; if (sel !== exp_sel) begin bad++; $display("FAIL rr_sel n=%0d got=%b exp=%b", n, sel, exp_sel); end
            total++; if (in0_ready !== !exp_sel) begin bad++; $display("FAIL rr_in0_ready n=%0d got=%b exp=%b", n, in0_ready, !exp_sel); end
            total++; if (in1_ready !== exp_sel) begin bad++; $display("FAIL rr_in1_ready n=%0d got=%b exp=%b", n, in1_ready, exp_sel); end
            if (n >= 2) begin
                exp_d = ((((n - 2) / 4) % 2) == 1) ? 8'hB1 : 8'hA0;
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_out_valid n=%0d got=%b exp=1", n, out_valid); end
                total++; if (out_data !== exp_d) begin bad++; $display("FAIL rr_out_data n=%0d got=%h exp=%h", n, out_data, exp_d); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        // two ch0 words accepted; stall the output for three cycles
        out_ready = 1'b0;
        in0_data  = 8'hFF;
        #1;
        total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_drop got=%b exp=0", in0_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid k=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL bp_out_data k=%0d got=%h exp=a0", k, out_data); end
            total++; if (sel !== 1'b0) begin bad++; $display("FAIL bp_sel k=%0d got=%b exp=0", k, sel); end
            total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL bp_in0_ready k=%0d got=%b exp=0", k, in0_ready); end
        end
        out_ready = 1'b1;
        in0_data  = 8'hA0;
        tick();
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL bp_resume_sel got=%b exp=0", sel); end
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL bp_resume_data got=%h exp=a0", out_data); end
        tick();
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL bp_switch_sel got=%b exp=1", sel); end
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL bp_fourth_data got=%h exp=a0", out_data); end
        tick();
        total++; if (out_data !== 8'hB1) begin bad++; $display("FAIL bp_ch1_data got=%h exp=b1", out_data); end
    endtask

    task automatic test_drop_and_idle();
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h11;
        in1_data  = 8'h21;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_data !== 8'h11) begin bad++; $display("FAIL drop_w1 got=%h exp=11", out_data); end
        in0_data = 8'h12;
        tick();
        total++; if (out_data !== 8'h12) begin bad++; $display("FAIL drop_w2 got=%h exp=12", out_data); end
        in0_valid = 1'b0;
        tick();
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL drop_sel got=%b exp=1", sel); end
        total++; if (in1_ready !== 1'b1) begin bad++; $display("FAIL drop_in1_ready got=%b exp=1", in1_ready); end
        total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL drop_in0_ready got=%b exp=0", in0_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_bubble got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drop_ch1_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h21) begin bad++; $display("FAIL drop_ch1_w1 got=%h exp=21", out_data); end
        in1_data = 8'h22;
        tick();
        total++; if (out_data !== 8'h22) begin bad++; $display("FAIL drop_ch1_w2 got=%h exp=22", out_data); end
        // everyone goes quiet while the output is stalled
        in1_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL idle_held_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h22) begin bad++; $display("FAIL idle_held_data got=%h exp=22", out_data); end
        total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL idle_in0_ready got=%b exp=0", in0_ready); end
        total++; if (in1_ready !== 1'b0) begin bad++; $display("FAIL idle_in1_ready got=%b exp=0", in1_ready); end
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL idle_sel_hold got=%b exp=1", sel); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_drain got=%b exp=0", out_valid); end
        tick();
        in1_valid = 1'b1;
        in1_data  = 8'h33;
        #1;
        total++; if (in1_ready !== 1'b0) begin bad++; $display("FAIL idle_no_ready got=%b exp=0", in1_ready); end
        tick();
        total++; if (in1_ready !== 1'b1) begin bad++; $display("FAIL regrant_ready got=%b exp=1", in1_ready); end
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL regrant_sel got=%b exp=1", sel); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL regrant_no_xfer got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL regrant_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h33) begin bad++; $display("FAIL regrant_data got=%h exp=33", out_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB1;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
        end
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL ar_pre_sel got=%b exp=1", sel); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL ar_out_data got=%h exp=00", out_data); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL ar_sel got=%b exp=0", sel); end
        total++; if (in0_ready !== 1'b0) begin bad++; $display("FAIL ar_in0_ready got=%b exp=0", in0_ready); end
        total++; if (in1_ready !== 1'b0) begin bad++; $display("FAIL ar_in1_ready got=%b exp=0", in1_ready); end
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL ar_first_sel got=%b exp=0", sel); end
        total++; if (in0_ready !== 1'b1) begin bad++; $display("FAIL ar_first_ready got=%b exp=1", in0_ready); end
        tick();
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL ar_first_data got=%h exp=a0", out_data); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = 8'h00;
        in1_data  = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_ch0_only();
        test_round_robin();
        test_backpressure();
        test_drop_and_idle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
